// File: rtl/mmc1_pkg.sv
// Shared encodings for the parametrised MMC1 mapper: register selects,
// mirroring and PRG banking modes, and serial-loader constants.
package mmc1_pkg;

  localparam int SHIFT_LEN = 5;
  localparam int CNT_W     = 3;
  localparam logic [SHIFT_LEN-1:0] CTRL_RESET = 5'b01100;

  typedef enum logic [1:0] {
    SEL_CTRL = 2'b00,
    SEL_CHR0 = 2'b01,
    SEL_CHR1 = 2'b10,
    SEL_PRG  = 2'b11
  } reg_sel_e;

  typedef enum logic [1:0] {
    MIR_ONE_LO = 2'b00,
    MIR_ONE_HI = 2'b01,
    MIR_VERT   = 2'b10,
    MIR_HORZ   = 2'b11
  } mirror_e;

  typedef enum logic [1:0] {
    PRG_32K_A  = 2'b00,
    PRG_32K_B  = 2'b01,
    PRG_FIX_LO = 2'b10,
    PRG_FIX_HI = 2'b11
  } prg_mode_e;

endpackage

// File: rtl/mmc1_serial_loader.sv
// Serial 5-bit loader: LSB-first shift register with the MMC1 consecutive-write
// filter; emits a one-cycle commit (value + select) and a D7 clear strobe.
module mmc1_serial_loader
  import mmc1_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic                 d7,
  input  logic                 d0,
  input  logic [1:0]           sel_in,
  output logic                 commit,
  output logic                 clear,
  output logic [SHIFT_LEN-1:0] value,
  output reg_sel_e             sel
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SHIFT_LEN - 1);

  logic [SHIFT_LEN-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 last_wr_q, last_wr_d;
  logic                 accept;

  // A D0 write landing right after another write cycle is dropped, but a
  // D7 write is always honoured.
  always_comb begin
    accept    = wr_en & ~d7 & ~last_wr_q;
    clear     = wr_en & d7;
    value     = {d0, shift_q[SHIFT_LEN-1:1]};
    commit    = accept & (cnt_q == CNT_LAST);
    sel       = reg_sel_e'(sel_in);
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    last_wr_d = wr_en;
    if (clear || commit) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (accept) begin
      shift_d = value;
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      shift_q   <= '0;
      cnt_q     <= '0;
      last_wr_q <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      last_wr_q <= last_wr_d;
    end
  end

endmodule

// File: rtl/mmc1_param_mapper.sv
// Parametrised MMC1 mapper top: internal registers, PRG/CHR bank muxing,
// nametable mirroring, and PRG/WRAM chip enables.
module mmc1_param_mapper
  import mmc1_pkg::*;
#(
  parameter int PRG_BANK_BITS = 4,
  parameter int CHR_BANK_BITS = 5,
  parameter int PRG_OUTER_EN  = 0,
  parameter int WRAM_CTRL_EN  = 1
) (
  input  logic                                  CPU_M2,
  input  logic                                  RESET,
  input  logic                                  nCPU_ROMSEL,
  input  logic                                  CPU_A14,
  input  logic                                  CPU_A13,
  input  logic                                  nCPU_RW,
  input  logic                                  CPU_D7,
  input  logic                                  CPU_D0,
  input  logic                                  PPU_A12,
  input  logic                                  PPU_A11,
  input  logic                                  PPU_A10,
  output logic                                  CIRAM_A10,
  output logic [PRG_BANK_BITS+PRG_OUTER_EN-1:0] PRG_A,
  output logic [CHR_BANK_BITS-1:0]              CHR_A,
  output logic                                  nPRG_CE,
  output logic                                  nWRAM_CE
);

  logic                 wr_event;
  logic                 commit, clear;
  logic [SHIFT_LEN-1:0] value;
  reg_sel_e             sel;

  logic [SHIFT_LEN-1:0] ctrl_q, ctrl_d;
  logic [SHIFT_LEN-1:0] chr0_q, chr0_d;
  logic [SHIFT_LEN-1:0] chr1_q, chr1_d;
  logic [SHIFT_LEN-1:0] prg_q, prg_d;

  logic [SHIFT_LEN-1:0]     chr_active;
  logic [PRG_BANK_BITS-1:0] prg_base, prg_bank;
  logic [CHR_BANK_BITS-1:0] chr_bank;
  logic                     outer_bit;
  logic                     wram_dis;
  logic                     unused_bits;

  assign wr_event = ~nCPU_ROMSEL & ~nCPU_RW;

  mmc1_serial_loader u_loader (
    .clk    (CPU_M2),
    .rst    (RESET),
    .wr_en  (wr_event),
    .d7     (CPU_D7),
    .d0     (CPU_D0),
    .sel_in ({CPU_A14, CPU_A13}),
    .commit (commit),
    .clear  (clear),
    .value  (value),
    .sel    (sel)
  );

  always_comb begin
    ctrl_d = ctrl_q;
    chr0_d = chr0_q;
    chr1_d = chr1_q;
    prg_d  = prg_q;
    if (clear) begin
      ctrl_d = ctrl_q | CTRL_RESET;
    end else if (commit) begin
      case (sel)
        SEL_CTRL: ctrl_d = value;
        SEL_CHR0: chr0_d = value;
        SEL_CHR1: chr1_d = value;
        SEL_PRG:  prg_d  = value;
        default:  ctrl_d = ctrl_q;
      endcase
    end
  end

  always_ff @(negedge CPU_M2 or posedge RESET) begin
    if (RESET) begin
      ctrl_q <= CTRL_RESET;
      chr0_q <= '0;
      chr1_q <= '0;
      prg_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      chr0_q <= chr0_d;
      chr1_q <= chr1_d;
      prg_q  <= prg_d;
    end
  end

  // The active CHR register also supplies the SUROM outer PRG bit, so fixed
  // banks stay within the currently selected 256 KB half.
  always_comb begin
    chr_active = (ctrl_q[4] & PPU_A12) ? chr1_q : chr0_q;
    outer_bit  = chr_active[4];

    case (mirror_e'(ctrl_q[1:0]))
      MIR_ONE_LO: CIRAM_A10 = 1'b0;
      MIR_ONE_HI: CIRAM_A10 = 1'b1;
      MIR_VERT:   CIRAM_A10 = PPU_A10;
      MIR_HORZ:   CIRAM_A10 = PPU_A11;
      default:    CIRAM_A10 = 1'b0;
    endcase

    prg_base = prg_q[PRG_BANK_BITS-1:0];
    prg_bank = prg_base;
    case (prg_mode_e'(ctrl_q[3:2]))
      PRG_32K_A, PRG_32K_B: prg_bank[0] = CPU_A14;
      PRG_FIX_LO:           prg_bank = CPU_A14 ? prg_base : '0;
      PRG_FIX_HI:           prg_bank = CPU_A14 ? '1 : prg_base;
      default:              prg_bank = prg_base;
    endcase

    if (ctrl_q[4]) begin
      chr_bank = chr_active[CHR_BANK_BITS-1:0];
    end else begin
      chr_bank    = chr0_q[CHR_BANK_BITS-1:0];
      chr_bank[0] = PPU_A12;
    end

    wram_dis = (WRAM_CTRL_EN != 0) && prg_q[4];
  end

  generate
    if (PRG_OUTER_EN != 0) begin : g_outer
      assign PRG_A = {outer_bit, prg_bank};
    end else begin : g_no_outer
      assign PRG_A = prg_bank;
    end
  endgenerate

  assign CHR_A    = chr_bank;
  assign nPRG_CE  = nCPU_ROMSEL | ~nCPU_RW;
  assign nWRAM_CE = ~(nCPU_ROMSEL & CPU_M2 & CPU_A14 & CPU_A13 & ~wram_dis);

  // Register bits that some parameter sets leave unread.
  assign unused_bits = ^{chr0_q, chr1_q, prg_q, outer_bit};

endmodule

// File: tb/tb_mmc1_param_mapper.sv
// Self-checking bench for mmc1_param_mapper (SUROM outer bank enabled):
// table of bus probes with hand-computed outputs, checked through a scoreboard queue.
module tb_mmc1_param_mapper;

  logic       CPU_M2 = 1'b0;
  logic       RESET;
  logic       nCPU_ROMSEL, CPU_A14, CPU_A13, nCPU_RW, CPU_D7, CPU_D0;
  logic       PPU_A12, PPU_A11, PPU_A10;
  logic       CIRAM_A10, nPRG_CE, nWRAM_CE;
  logic [4:0] PRG_A;
  logic [4:0] CHR_A;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         step;
    string      name;
    logic       a14, a13, romsel_n, rw_n, a12, a11, a10;
    logic       ciram;
    logic [4:0] prg;
    logic [4:0] chr;
    logic       nprg, nwram;
  } probe_t;

  probe_t tbl[$];
  probe_t exp_q[$];

  mmc1_param_mapper #(
    .PRG_BANK_BITS(4),
    .CHR_BANK_BITS(5),
    .PRG_OUTER_EN (1),
    .WRAM_CTRL_EN (1)
  ) dut (
    .CPU_M2     (CPU_M2),
    .RESET      (RESET),
    .nCPU_ROMSEL(nCPU_ROMSEL),
    .CPU_A14    (CPU_A14),
    .CPU_A13    (CPU_A13),
    .nCPU_RW    (nCPU_RW),
    .CPU_D7     (CPU_D7),
    .CPU_D0     (CPU_D0),
    .PPU_A12    (PPU_A12),
    .PPU_A11    (PPU_A11),
    .PPU_A10    (PPU_A10),
    .CIRAM_A10  (CIRAM_A10),
    .PRG_A      (PRG_A),
    .CHR_A      (CHR_A),
    .nPRG_CE    (nPRG_CE),
    .nWRAM_CE   (nWRAM_CE)
  );

  always #10 CPU_M2 = ~CPU_M2;

  task automatic add_probe(input int step, input string name,
                           input logic a14, a13, romsel_n, rw_n, a12, a11, a10,
                           input logic ciram, input logic [4:0] prg, chr,
                           input logic nprg, nwram);
    probe_t p;
    p.step = step; p.name = name;
    p.a14 = a14; p.a13 = a13; p.romsel_n = romsel_n; p.rw_n = rw_n;
    p.a12 = a12; p.a11 = a11; p.a10 = a10;
    p.ciram = ciram; p.prg = prg; p.chr = chr; p.nprg = nprg; p.nwram = nwram;
    tbl.push_back(p);
  endtask

  task automatic bus_idle();
    nCPU_ROMSEL = 1'b1; nCPU_RW = 1'b1;
    CPU_A14 = 1'b0; CPU_A13 = 1'b0; CPU_D7 = 1'b0; CPU_D0 = 1'b0;
    PPU_A12 = 1'b0; PPU_A11 = 1'b0; PPU_A10 = 1'b0;
  endtask

  task automatic wait_high();
    @(posedge CPU_M2);
    #2;
  endtask

  task automatic compare(input string name, input logic [4:0] act, input logic [4:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input probe_t p);
    nCPU_ROMSEL = p.romsel_n; nCPU_RW = p.rw_n;
    CPU_A14 = p.a14; CPU_A13 = p.a13;
    PPU_A12 = p.a12; PPU_A11 = p.a11; PPU_A10 = p.a10;
    exp_q.push_back(p);
  endtask

  task automatic check_output();
    probe_t e;
    e = exp_q.pop_front();
    compare({e.name, ".ciram"}, {4'b0, CIRAM_A10}, {4'b0, e.ciram});
    compare({e.name, ".prg"},   PRG_A,             e.prg);
    compare({e.name, ".chr"},   CHR_A,             e.chr);
    compare({e.name, ".nprg"},  {4'b0, nPRG_CE},   {4'b0, e.nprg});
    compare({e.name, ".nwram"}, {4'b0, nWRAM_CE},  {4'b0, e.nwram});
    bus_idle();
  endtask

  task automatic run_step(input int step);
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].step == step) begin
        wait_high();
        apply_stimulus(tbl[i]);
        #2;
        check_output();
      end
    end
  endtask

  // One mapper write followed by an idle falling edge so the next is not consecutive.
  task automatic write_once(input logic [1:0] sel, input logic d7, input logic d0);
    wait_high();
    nCPU_ROMSEL = 1'b0; nCPU_RW = 1'b0;
    {CPU_A14, CPU_A13} = sel; CPU_D7 = d7; CPU_D0 = d0;
    @(negedge CPU_M2);
    #1;
    bus_idle();
    @(negedge CPU_M2);
    #1;
  endtask

  task automatic write_b2b(input logic [1:0] sel, input logic d7a, d0a, d7b, d0b);
    wait_high();
    nCPU_ROMSEL = 1'b0; nCPU_RW = 1'b0;
    {CPU_A14, CPU_A13} = sel; CPU_D7 = d7a; CPU_D0 = d0a;
    @(negedge CPU_M2);
    #1;
    CPU_D7 = d7b; CPU_D0 = d0b;
    @(negedge CPU_M2);
    #1;
    bus_idle();
    @(negedge CPU_M2);
    #1;
  endtask

  task automatic load_reg(input logic [1:0] sel, input logic [4:0] val);
    for (int i = 0; i < 5; i++) write_once(sel, 1'b0, val[i]);
  endtask

  initial begin
    //          step name      a14 a13 rs rw a12 a11 a10 ciram prg    chr    nprg nwram
    add_probe(0, "rst_lo",    0, 0, 0, 1, 0, 0, 0,  0, 5'h00, 5'h00, 0, 1);
    add_probe(0, "rst_hi",    1, 0, 0, 1, 1, 1, 1,  0, 5'h0F, 5'h01, 0, 1);
    add_probe(0, "rst_wram",  1, 1, 1, 1, 0, 0, 0,  0, 5'h0F, 5'h00, 1, 0);
    add_probe(1, "vert_lo",   0, 0, 0, 1, 0, 0, 1,  1, 5'h03, 5'h00, 0, 1);
    add_probe(1, "vert_hi",   1, 0, 0, 1, 1, 1, 0,  0, 5'h0F, 5'h01, 0, 1);
    add_probe(1, "vert_wr",   1, 1, 0, 0, 0, 0, 1,  1, 5'h0F, 5'h00, 1, 1);
    add_probe(2, "filt_hold", 0, 0, 0, 1, 0, 0, 1,  1, 5'h03, 5'h00, 0, 1);
    add_probe(3, "filt_hi",   1, 0, 0, 1, 0, 1, 0,  1, 5'h03, 5'h00, 0, 1);
    add_probe(3, "filt_lo",   0, 0, 0, 1, 1, 0, 1,  0, 5'h02, 5'h01, 0, 1);
    add_probe(4, "d7_hi",     1, 0, 0, 1, 0, 1, 1,  0, 5'h0F, 5'h00, 0, 1);
    add_probe(4, "d7_lo",     0, 0, 0, 1, 0, 0, 0,  0, 5'h03, 5'h00, 0, 1);
    add_probe(5, "chr4_lo",   0, 0, 0, 1, 0, 0, 0,  0, 5'h02, 5'h05, 0, 1);
    add_probe(5, "chr4_hi",   1, 0, 0, 1, 1, 0, 0,  0, 5'h13, 5'h1A, 0, 1);
    add_probe(6, "chr8_lo",   0, 0, 0, 1, 0, 0, 0,  0, 5'h02, 5'h04, 0, 1);
    add_probe(6, "chr8_hi",   1, 0, 0, 1, 1, 0, 0,  0, 5'h03, 5'h05, 0, 1);
    add_probe(7, "outer_hi",  1, 0, 0, 1, 0, 0, 0,  0, 5'h1F, 5'h10, 0, 1);
    add_probe(7, "outer_lo",  0, 0, 0, 1, 0, 0, 0,  0, 5'h13, 5'h10, 0, 1);
    add_probe(8, "wram_dis",  1, 1, 1, 1, 0, 0, 0,  0, 5'h1F, 5'h10, 1, 1);
    add_probe(8, "wram_lo",   0, 0, 0, 1, 0, 0, 0,  0, 5'h10, 5'h10, 0, 1);

    bus_idle();
    RESET = 1'b1;
    #15;
    RESET = 1'b0;

    // Partial load, then reset while a write is on the bus.
    write_once(2'b00, 1'b0, 1'b1);
    write_once(2'b00, 1'b0, 1'b1);
    write_once(2'b00, 1'b0, 1'b1);
    wait_high();
    nCPU_ROMSEL = 1'b0; nCPU_RW = 1'b0; CPU_D0 = 1'b1;
    RESET = 1'b1;
    @(negedge CPU_M2);
    #1;
    RESET = 1'b0;
    bus_idle();
    @(negedge CPU_M2);
    #1;
    run_step(0);

    load_reg(2'b00, 5'h0E);
    load_reg(2'b11, 5'h03);
    run_step(1);

    // Back-to-back pair counts once; three spaced writes leave cnt at 4.
    write_b2b(2'b00, 1'b0, 1'b1, 1'b0, 1'b1);
    write_once(2'b00, 1'b0, 1'b1);
    write_once(2'b00, 1'b0, 1'b0);
    write_once(2'b00, 1'b0, 1'b0);
    run_step(2);
    write_once(2'b00, 1'b0, 1'b0);
    run_step(3);

    // D7 immediately after the third bit must still clear the loader.
    load_reg(2'b00, 5'h00);
    write_once(2'b00, 1'b0, 1'b1);
    write_once(2'b00, 1'b0, 1'b1);
    write_b2b(2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    run_step(4);

    load_reg(2'b00, 5'h10);
    load_reg(2'b01, 5'h05);
    load_reg(2'b10, 5'h1A);
    run_step(5);

    load_reg(2'b00, 5'h00);
    run_step(6);

    load_reg(2'b01, 5'h10);
    load_reg(2'b00, 5'h0C);
    run_step(7);

    load_reg(2'b11, 5'h10);
    run_step(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmc1_param_mapper.md
Name: mmc1_param_mapper

Overview:
- Parametrised successor to the MMC1 mapper: serial 5-bit register loader, PRG/CHR bank address generation, nametable mirroring, WRAM chip-enable.
- Adds the following over the previous generation:
  - generic PRG/CHR bank widths
  - an optional SUROM-style 512 KB outer PRG bank
  - a WRAM-disable bit
  - the MMC1 consecutive-write filter
  - an explicit asynchronous reset
- Sits between the cartridge edge (CPU/PPU bus) and the PRG ROM, CHR ROM/RAM, WRAM and CIRAM.

Parameters:
- PRG_BANK_BITS, 4, bits of 16 KB PRG bank number from the PRG register (1..4).
- CHR_BANK_BITS, 5, bits of 4 KB CHR bank number (1..5).
- PRG_OUTER_EN, 0, 1 = CHR-register bit 4 drives an extra PRG address bit (512 KB, SUROM).
- WRAM_CTRL_EN, 1, 1 = PRG-register bit 4 disables WRAM.

Ports:
- CPU_M2  in  1  single clock; all state updates on the falling edge of CPU_M2.
- RESET  in  1  asynchronous, active-high reset.
- nCPU_ROMSEL  in  1  low = $8000-$FFFF access.
- CPU_A14, CPU_A13  in  1 each  register select / PRG half / WRAM decode.
- nCPU_RW  in  1  low = CPU write.
- CPU_D7, CPU_D0  in  1 each  reset bit / serial data bit.
- PPU_A12, PPU_A11, PPU_A10  in  1 each  PPU address.
- CIRAM_A10  out  1  nametable select.
- PRG_A  out  PRG_BANK_BITS+PRG_OUTER_EN  PRG ROM A14 and up.
- CHR_A  out  CHR_BANK_BITS  CHR A12 and up.
- nPRG_CE  out  1  PRG ROM enable, active low.
- nWRAM_CE  out  1  WRAM enable, active low.

Behaviour:
- Reset (async, RESET=1) sets:
  - shift=0, cnt=0, last_wr=0
  - ctrl=5'b01100
  - chr0=chr1=prg=0
- Resulting outputs at reset:
  - CIRAM_A10=0
  - PRG_A = all ones when CPU_A14=1, else {outer=0, bank 0}
  - CHR_A={chr0[..:1],PPU_A12}
  - nWRAM_CE active for $6000-$7FFF
- Reset mid-sequence discards the partial shift.
- Mapper write event: negedge CPU_M2 with nCPU_ROMSEL=0 and nCPU_RW=0.
- Consecutive-write filter:
  - last_wr <= current write event, updated every falling edge.
  - A D0 write with last_wr=1 is ignored; cnt and shift are unchanged.
- D7=1 write:
  - Always honoured, even when consecutive.
  - Sets shift=0, cnt=0, ctrl <= ctrl | 5'b01100.
- D7=0 accepted write:
  - cnt<4: shift <= {D0, shift[4:1]}, cnt++.
  - cnt==4: value {D0, shift[4:1]} goes to the register selected by A14:A13 (00 ctrl, 01 chr0, 10 chr1, 11 prg); then shift=0, cnt=0.
- Mirroring, ctrl[1:0]:
  - 00 -> 0
  - 01 -> 1
  - 10 -> PPU_A10
  - 11 -> PPU_A11
- PRG, ctrl[3:2], where b = prg[PRG_BANK_BITS-1:0]:
  - 0x -> {b[..:1], CPU_A14}
  - 10 -> A14 ? b : 0
  - 11 -> A14 ? all ones : b
- PRG outer bit (PRG_OUTER_EN=1): MSB = bit 4 of the active CHR register (chr1 if ctrl[4] & PPU_A12, else chr0), applied in all modes. Fixed banks stay inside the selected 256 KB half.
- CHR:
  - ctrl[4]=1 -> (PPU_A12 ? chr1 : chr0) low bits.
  - ctrl[4]=0 -> {chr0[..:1], PPU_A12}.
- nPRG_CE = nCPU_ROMSEL | ~nCPU_RW (combinational).
- nWRAM_CE:
  - Low iff nCPU_ROMSEL=1 & CPU_M2 & CPU_A14 & CPU_A13 & ~(WRAM_CTRL_EN & prg[4]).
  - The CPU_A15 low case is assumed by board decode.
- All address outputs are combinational from registers and bus; no latency beyond register update at the falling edge.

Decomposition:
- mmc1_pkg holds:
  - register select codes
  - mirroring and PRG mode encodings
  - CTRL_RESET=5'b01100
  - shift length 5
- Sub-module mmc1_serial_loader holds shift, cnt and last_wr. It outputs a commit strobe, the 5-bit value and the 2-bit select; the top holds registers and muxes.

Test Plan:
- Reset asserted mid-bus-cycle -> ctrl=0x0C, CIRAM_A10=0, PRG_A=all ones at A14=1, 0 at A14=0; any partial load is lost.
- Five non-consecutive writes to $8000, D0 = 0,1,1,1,0 (ctrl=0x0E) -> vertical mirroring (CIRAM_A10 follows PPU_A10), PRG mode 3; prg=3 gives PRG_A=3 at $8000 and 0xF at $C000.
- Two back-to-back writes (D0=1 each), then three spaced writes -> only 4 bits accepted, no commit; a fifth spaced write commits.
- Three bits loaded, then a D7=1 write with ctrl=0x00 -> ctrl=0x0C, cnt=0; the next five writes commit cleanly.
- ctrl=0x10, chr0=0x05, chr1=0x1A -> CHR_A=0x05 at PPU_A12=0, 0x1A at PPU_A12=1. Then ctrl=0x00 -> CHR_A=0x04 or 0x05 following PPU_A12.
- PRG_OUTER_EN=1, chr0=0x10, mode 3 -> PRG_A at $C000 = 0x1F. prg=0x10 -> nWRAM_CE stays high for a $6000 read.
